// File: rtl/steer_sequencer.sv
// steer_sequencer: picks the highest-priority steering request and walks the
// servo direction code toward it one scale position at a time, holding each
// position for a minimum dwell. A long silence from every requester returns
// the wheels to straight and raises lost.
module steer_sequencer #(
  parameter int DWELL_US   = 100000,
  parameter int TIMEOUT_US = 500000
) (
  input  logic       clkus,
  input  logic       rst_n,
  input  logic       man_valid,
  input  logic [2:0] man_dir,
  input  logic       obs_valid,
  input  logic [2:0] obs_dir,
  input  logic       trk_valid,
  input  logic [2:0] trk_dir,
  output logic [2:0] direction,
  output logic       busy,
  output logic [1:0] src,
  output logic       lost
);

  // Scale index 0..4 runs from hard right to hard left; 2 is straight.
  localparam logic [2:0]  IDX_STRAIGHT = 3'd2;
  localparam logic [16:0] DWELL_RELOAD = 17'(DWELL_US - 1);
  localparam logic [19:0] TO_LAST      = 20'(TIMEOUT_US - 1);
  localparam logic [19:0] TO_MAX       = 20'(TIMEOUT_US);

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_TRK  = 2'd1;
  localparam logic [1:0] SRC_OBS  = 2'd2;
  localparam logic [1:0] SRC_MAN  = 2'd3;

  // Any code outside the five legal ones is treated as straight.
  function automatic logic [2:0] code_to_idx(input logic [2:0] code);
    logic [2:0] idx;
    case (code)
      3'b111:  idx = 3'd0;
      3'b101:  idx = 3'd1;
      3'b001:  idx = 3'd3;
      3'b011:  idx = 3'd4;
      default: idx = IDX_STRAIGHT;
    endcase
    return idx;
  endfunction

  // Only legal codes can come out, whatever the index holds.
  function automatic logic [2:0] idx_to_code(input logic [2:0] idx);
    logic [2:0] code;
    case (idx)
      3'd0:    code = 3'b111;
      3'd1:    code = 3'b101;
      3'd3:    code = 3'b001;
      3'd4:    code = 3'b011;
      default: code = 3'b000;
    endcase
    return code;
  endfunction

  logic [2:0]  pos_q, pos_d;
  logic [2:0]  tgt_q, tgt_d;
  logic [1:0]  src_q, src_d;
  logic        lost_q, lost_d;
  logic        busy_q, busy_d;
  logic [16:0] hold_cnt_q, hold_cnt_d;
  logic [19:0] to_cnt_q, to_cnt_d;

  // State register: every piece of state returns to straight/idle on reset.
  always_ff @(posedge clkus or negedge rst_n) begin
    if (!rst_n) begin
      pos_q      <= IDX_STRAIGHT;
      tgt_q      <= IDX_STRAIGHT;
      src_q      <= SRC_NONE;
      lost_q     <= 1'b0;
      busy_q     <= 1'b0;
      hold_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      pos_q      <= pos_d;
      tgt_q      <= tgt_d;
      src_q      <= src_d;
      lost_q     <= lost_d;
      busy_q     <= busy_d;
      hold_cnt_q <= hold_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  // Arbitration and timeout: winner loads target; silence counts toward straight.
  always_comb begin
    tgt_d    = tgt_q;
    src_d    = src_q;
    lost_d   = lost_q;
    to_cnt_d = to_cnt_q;
    if (man_valid) begin
      tgt_d    = code_to_idx(man_dir);
      src_d    = SRC_MAN;
      lost_d   = 1'b0;
      to_cnt_d = '0;
    end else if (obs_valid) begin
      tgt_d    = code_to_idx(obs_dir);
      src_d    = SRC_OBS;
      lost_d   = 1'b0;
      to_cnt_d = '0;
    end else if (trk_valid) begin
      tgt_d    = code_to_idx(trk_dir);
      src_d    = SRC_TRK;
      lost_d   = 1'b0;
      to_cnt_d = '0;
    end else begin
      if (to_cnt_q != TO_MAX) begin
        to_cnt_d = to_cnt_q + 20'd1;
      end
      // Fires once: the counter saturates past this value and never returns.
      if (to_cnt_q == TO_LAST) begin
        tgt_d  = IDX_STRAIGHT;
        src_d  = SRC_NONE;
        lost_d = 1'b1;
      end
    end
  end

  // Stepping: one index per allowed edge toward the registered target, then dwell.
  always_comb begin
    pos_d      = pos_q;
    hold_cnt_d = hold_cnt_q;
    if ((hold_cnt_q == '0) && (pos_q != tgt_q)) begin
      pos_d      = (tgt_q > pos_q) ? (pos_q + 3'd1) : (pos_q - 3'd1);
      hold_cnt_d = DWELL_RELOAD;
    end else if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - 17'd1;
    end
    busy_d = (hold_cnt_q != '0) || (pos_q != tgt_q);
  end

  // Outputs come straight from registered state.
  always_comb begin
    direction = idx_to_code(pos_q);
    busy      = busy_q;
    src       = src_q;
    lost      = lost_q;
  end

endmodule

// File: tb/tb_steer_sequencer.sv
// Bench for steer_sequencer: vector table, directed timing sequences and a
// randomized run, all checked every cycle against a timestamp-based model.
module tb_steer_sequencer;

  localparam int DWELL   = 10;
  localparam int TIMEOUT = 50;

  logic       clkus = 1'b0;
  logic       rst_n = 1'b0;
  logic       man_valid = 1'b0, obs_valid = 1'b0, trk_valid = 1'b0;
  logic [2:0] man_dir = 3'd0, obs_dir = 3'd0, trk_dir = 3'd0;
  logic [2:0] direction;
  logic       busy;
  logic [1:0] src;
  logic       lost;

  steer_sequencer #(.DWELL_US(DWELL), .TIMEOUT_US(TIMEOUT)) dut (
    .clkus(clkus), .rst_n(rst_n),
    .man_valid(man_valid), .man_dir(man_dir),
    .obs_valid(obs_valid), .obs_dir(obs_dir),
    .trk_valid(trk_valid), .trk_dir(trk_dir),
    .direction(direction), .busy(busy), .src(src), .lost(lost)
  );

  always #5 clkus = ~clkus;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position on the scale plus the time of the last step.
  int     m_pos, m_tgt, m_src, m_idle;
  bit     m_lost, m_busy;
  longint m_cyc, m_last;

  function automatic int idx_of(input logic [2:0] code);
    case (code)
      3'b111:  return 0;
      3'b101:  return 1;
      3'b001:  return 3;
      3'b011:  return 4;
      default: return 2;
    endcase
  endfunction

  function automatic logic [2:0] code_of(input int idx);
    logic [2:0] tab [5];
    tab = '{3'b111, 3'b101, 3'b000, 3'b001, 3'b011};
    return tab[idx];
  endfunction

  task automatic model_reset();
    m_pos = 2; m_tgt = 2; m_src = 0; m_idle = 0;
    m_lost = 0; m_busy = 0; m_cyc = 0; m_last = -1000;
  endtask

  task automatic model_edge();
    int old_pos, old_tgt;
    m_cyc++;
    old_pos = m_pos;
    old_tgt = m_tgt;
    m_busy = ((m_cyc - m_last) < DWELL) || (old_pos != old_tgt);
    if (((m_cyc - m_last) >= DWELL) && (old_pos != old_tgt)) begin
      m_pos  = (old_tgt > old_pos) ? old_pos + 1 : old_pos - 1;
      m_last = m_cyc;
    end
    if (man_valid || obs_valid || trk_valid) begin
      if (man_valid)      begin m_tgt = idx_of(man_dir); m_src = 3; end
      else if (obs_valid) begin m_tgt = idx_of(obs_dir); m_src = 2; end
      else                begin m_tgt = idx_of(trk_dir); m_src = 1; end
      m_idle = 0;
      m_lost = 0;
    end else begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_tgt = 2; m_src = 0; m_lost = 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk($sformatf("%s model cyc%0d {dir,busy,src,lost}", tag, m_cyc),
        {1'b0, direction, busy, src, lost},
        {1'b0, code_of(m_pos), m_busy, 2'(m_src), m_lost});
  endtask

  task automatic tick(input string tag);
    @(posedge clkus);
    model_edge();
    #1;
    chk_model(tag);
  endtask

  task automatic run_to(input string tag, input int n);
    while (m_cyc < n) tick(tag);
  endtask

  task automatic set_in(input bit mv, input logic [2:0] md, input bit ov,
                        input logic [2:0] od, input bit tv, input logic [2:0] td);
    man_valid = mv; man_dir = md;
    obs_valid = ov; obs_dir = od;
    trk_valid = tv; trk_dir = td;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clkus);
    #2;
    model_reset();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         mv; logic [2:0] md;
    bit         ov; logic [2:0] od;
    bit         tv; logic [2:0] td;
    int         cycles;
    logic [2:0] e_dir;
    bit         e_busy;
    logic [1:0] e_src;
    bit         e_lost;
  } vec_t;

  vec_t tbl [18];

  initial begin
    // Table: priority, stepping, undefined codes and the timeout boundary.
    tbl[0]  = '{0,3'b000, 0,3'b000, 0,3'b000,   1, 3'b000, 0, 2'd0, 0};
    tbl[1]  = '{0,3'b000, 1,3'b001, 1,3'b111,   2, 3'b001, 1, 2'd2, 0};
    tbl[2]  = '{0,3'b000, 1,3'b001, 1,3'b111,  10, 3'b001, 0, 2'd2, 0};
    tbl[3]  = '{1,3'b111, 1,3'b001, 1,3'b111,   1, 3'b001, 0, 2'd3, 0};
    tbl[4]  = '{1,3'b111, 1,3'b001, 1,3'b111,   1, 3'b000, 1, 2'd3, 0};
    tbl[5]  = '{1,3'b111, 1,3'b001, 1,3'b111,   9, 3'b000, 1, 2'd3, 0};
    tbl[6]  = '{1,3'b111, 1,3'b001, 1,3'b111,   1, 3'b101, 1, 2'd3, 0};
    tbl[7]  = '{1,3'b111, 1,3'b001, 1,3'b111,  10, 3'b111, 1, 2'd3, 0};
    tbl[8]  = '{1,3'b111, 1,3'b001, 1,3'b111,  10, 3'b111, 0, 2'd3, 0};
    tbl[9]  = '{0,3'b000, 0,3'b000, 1,3'b001,  40, 3'b001, 0, 2'd1, 0};
    tbl[10] = '{0,3'b000, 0,3'b000, 1,3'b110,   1, 3'b001, 0, 2'd1, 0};
    tbl[11] = '{0,3'b000, 0,3'b000, 1,3'b110,   1, 3'b000, 1, 2'd1, 0};
    tbl[12] = '{0,3'b000, 0,3'b000, 1,3'b110,  10, 3'b000, 0, 2'd1, 0};
    tbl[13] = '{0,3'b000, 0,3'b000, 0,3'b000,  49, 3'b000, 0, 2'd1, 0};
    tbl[14] = '{0,3'b000, 0,3'b000, 0,3'b000,   1, 3'b000, 0, 2'd0, 1};
    tbl[15] = '{0,3'b000, 0,3'b000, 0,3'b000, 100, 3'b000, 0, 2'd0, 1};
    tbl[16] = '{0,3'b000, 1,3'b100, 0,3'b000,   1, 3'b000, 0, 2'd2, 0};
    tbl[17] = '{1,3'b011, 1,3'b111, 0,3'b000,   2, 3'b001, 1, 2'd3, 0};

    set_in(0, 0, 0, 0, 0, 0);
    do_reset();
    #1;
    chk("reset dir", {5'd0, direction}, 8'd0);
    chk("reset busy/src/lost", {4'd0, busy, src, lost}, 8'd0);

    for (int i = 0; i < 18; i++) begin
      set_in(tbl[i].mv, tbl[i].md, tbl[i].ov, tbl[i].od, tbl[i].tv, tbl[i].td);
      repeat (tbl[i].cycles) tick("table");
      $display("[TB] vec %0d: dir=%b busy=%0b src=%0d lost=%0b", i, direction, busy, src, lost);
      chk($sformatf("vec%0d dir", i), {5'd0, direction}, {5'd0, tbl[i].e_dir});
      chk($sformatf("vec%0d busy/src/lost", i), {4'd0, busy, src, lost},
          {4'd0, tbl[i].e_busy, tbl[i].e_src, tbl[i].e_lost});
    end

    // Step spacing from reset, then timeout back to straight and recovery.
    set_in(0, 0, 0, 0, 1, 3'b011);
    do_reset();
    run_to("seq1", 1);  chk("s1 e1 dir/src", {3'd0, direction, src}, {3'd0, 3'b000, 2'd1});
    chk("s1 e1 busy", {7'd0, busy}, 8'd0);
    run_to("seq1", 2);  chk("s1 e2 dir", {5'd0, direction}, {5'd0, 3'b001});
    run_to("seq1", 11); chk("s1 e11 dir", {5'd0, direction}, {5'd0, 3'b001});
    run_to("seq1", 12); chk("s1 e12 dir", {5'd0, direction}, {5'd0, 3'b011});
    run_to("seq1", 21); chk("s1 e21 busy", {7'd0, busy}, 8'd1);
    run_to("seq1", 22); chk("s1 e22 busy", {7'd0, busy}, 8'd0);
    run_to("seq4", 25);
    set_in(0, 0, 0, 0, 0, 0);
    run_to("seq4", 74); chk("s4 e74 lost/src", {5'd0, lost, src}, {5'd0, 1'b0, 2'd1});
    run_to("seq4", 75); chk("s4 e75 lost/src", {5'd0, lost, src}, {5'd0, 1'b1, 2'd0});
    run_to("seq4", 76); chk("s4 e76 dir", {5'd0, direction}, {5'd0, 3'b001});
    run_to("seq4", 86); chk("s4 e86 dir", {5'd0, direction}, {5'd0, 3'b000});
    run_to("seq4", 90);
    set_in(0, 0, 0, 0, 1, 3'b101);
    run_to("seq4", 91); chk("s4 e91 lost/src", {5'd0, lost, src}, {5'd0, 1'b0, 2'd1});
    run_to("seq4", 95); chk("s4 e95 dir", {5'd0, direction}, {5'd0, 3'b000});
    run_to("seq4", 96); chk("s4 e96 dir", {5'd0, direction}, {5'd0, 3'b101});
    $display("[TB] seq1/seq4 done at cycle %0d", m_cyc);

    // Retarget to the opposite side during a dwell.
    set_in(0, 0, 0, 0, 1, 3'b011);
    do_reset();
    run_to("seq3", 5);
    trk_dir = 3'b101;
    run_to("seq3", 11); chk("s3 e11 dir", {5'd0, direction}, {5'd0, 3'b001});
    run_to("seq3", 12); chk("s3 e12 dir", {5'd0, direction}, {5'd0, 3'b000});
    run_to("seq3", 21); chk("s3 e21 dir", {5'd0, direction}, {5'd0, 3'b000});
    run_to("seq3", 22); chk("s3 e22 dir", {5'd0, direction}, {5'd0, 3'b101});
    $display("[TB] seq3 done at cycle %0d", m_cyc);

    // Reset in the middle of a dwell: immediate clear, no leftover dwell.
    set_in(0, 0, 0, 0, 1, 3'b011);
    do_reset();
    run_to("seq6", 15);
    chk("s6 pre dir/busy", {4'd0, direction, busy}, {4'd0, 3'b011, 1'b1});
    rst_n = 1'b0;
    #1;
    chk("s6 async dir/busy/src/lost", {1'b0, direction, busy, src, lost}, 8'd0);
    model_reset();
    rst_n = 1'b1;
    run_to("seq6", 2); chk("s6 e2 dir", {5'd0, direction}, {5'd0, 3'b001});
    $display("[TB] seq6 done at cycle %0d", m_cyc);

    // Randomized segments checked against the model every cycle.
    for (int seg = 0; seg < 80; seg++) begin
      int r, len;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        set_in(0, 0, 0, 0, 0, 0);
        len = $urandom_range(40, 70);
      end else if (r == 2) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_model("rand-reset");
        rst_n = 1'b1;
        len = $urandom_range(1, 20);
      end else begin
        set_in($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
               $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
               $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)));
        len = $urandom_range(1, 25);
      end
      repeat (len) tick("rand");
      $display("[TB] seg %0d: man=%0b/%b obs=%0b/%b trk=%0b/%b len=%0d -> dir=%b src=%0d lost=%0b",
               seg, man_valid, man_dir, obs_valid, obs_dir, trk_valid, trk_dir, len,
               direction, src, lost);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/steer_sequencer.md
Name: steer_sequencer

Overview:
- Arbitrates steering requests from three sources and drives the 3-bit front-wheel direction code into the servo PWM block.
- Sources, highest priority first: manual/remote override, obstacle avoider, line tracker.
- The output moves one position at a time along the steering scale, with a minimum dwell between steps, so the servo never jumps end-to-end.
- Loss of all requesters for a timeout period forces steering back to straight.

Parameters:
- DWELL_US, 100000: minimum clkus cycles between consecutive direction steps (100 ms). Legal range 1..131071; counter is 17 bits.
- TIMEOUT_US, 500000: consecutive clkus cycles with no valid request before forcing STRAIGHT. Legal range 1..1048575; counter is 20 bits.

Ports:
- clkus  in  1  1 MHz clock (1 us tick)
- rst_n  in  1  asynchronous active-low reset
- man_valid  in  1  manual request valid
- man_dir  in  3  manual requested direction code
- obs_valid  in  1  obstacle-avoider request valid
- obs_dir  in  3  obstacle-avoider requested direction code
- trk_valid  in  1  line-tracker request valid
- trk_dir  in  3  line-tracker requested direction code
- direction  out  3  direction code to servo block
- busy  out  1  high while stepping or dwelling
- src  out  2  source of current target: 0 = none/held, 1 = trk, 2 = obs, 3 = man
- lost  out  1  high while timeout-forced STRAIGHT is active

Behaviour:
- Direction codes: STRAIGHT = 000, LEFT_SMALL = 001, LEFT_BIG = 011, RIGHT_SMALL = 101, RIGHT_BIG = 111.
- Scale index: RIGHT_BIG = 0, RIGHT_SMALL = 1, STRAIGHT = 2, LEFT_SMALL = 3, LEFT_BIG = 4.
- Undefined input codes (010, 100, 110) map to index 2.
- All outputs are driven only from registered index/state; they never carry an undefined code.
- Reset (rst_n low, async):
  - pos = 2, tgt = 2, hold_cnt = 0, to_cnt = 0.
  - Outputs: direction = 000, busy = 0, src = 0, lost = 0.
- Arbitration (each edge, registered into tgt/src):
  - man_valid wins, then obs_valid, then trk_valid.
  - The winner's index loads into tgt; src gets the winner id; to_cnt clears; lost clears.
- No source valid:
  - to_cnt increments, saturating at TIMEOUT_US.
  - tgt and src hold until to_cnt reaches TIMEOUT_US-1 on an edge.
  - On that edge: tgt = 2, src = 0, lost = 1.
  - lost stays 1 until any valid is seen; that same edge clears lost and loads the new target.
- Stepping (same edge, using registered tgt):
  - If hold_cnt == 0 and pos != tgt: pos moves one index toward tgt and hold_cnt loads DWELL_US-1.
  - Else if hold_cnt != 0: hold_cnt decrements.
  - Consecutive steps are therefore exactly DWELL_US cycles apart.
  - With DWELL_US = 1, a step is allowed every cycle.
- Latency: a request presented before edge k loads tgt at edge k. The first step, if not dwelling, occurs at edge k+1. direction is registered from pos, so it changes at edge k+1.
- Retargeting mid-move:
  - The new tgt takes effect at the next allowed step.
  - A reversal is allowed; it still waits out the remaining dwell.
  - No step is skipped.
- Dwell persists after reaching target: pos stays and hold_cnt keeps counting down.
- busy = (hold_cnt != 0) or (pos != tgt), registered.
- Simultaneous valids: only the highest-priority source is used. Lower requests are dropped, not queued.
- Reset mid-move: returns immediately (asynchronously) to direction = 000 and discards the remaining dwell.

Test Plan:
- Bench parameters for all scenarios: DWELL_US = 10, TIMEOUT_US = 50.
1. Reset release, trk_valid = 1, trk_dir = 011 -> direction 000 -> 001 at edge 2, then 001 -> 011 exactly 10 cycles later; busy drops 10 cycles after the final step; src = 1.
2. trk_dir = 111 and obs_dir = 001 both valid -> src = 2; direction goes 000 -> 001 only; trk request ignored. Then add man_dir = 111 -> src = 3; direction steps 001 -> 000 -> 101 -> 111, 10 cycles apart.
3. Retarget mid-dwell: heading to LEFT_BIG, at 001 after 3 dwell cycles switch trk_dir to 101 -> next step at cycle 10 goes to 000, then 101 10 cycles later; no step occurs before the dwell expires.
4. Drop all valids while at 011 -> after 50 idle cycles lost = 1 and src = 0; direction steps 001 then 000. Reassert trk_valid with trk_dir = 101 -> lost = 0 on that edge; steps to 101.
5. Invalid code: trk_dir = 110 from LEFT_SMALL -> tgt = STRAIGHT; direction returns to 000 and never shows 110.
6. Assert rst_n low mid-dwell at 011 -> direction = 000, busy = 0, lost = 0 immediately; after release the first step is allowed without waiting out the old dwell.
